// File: rtl/arc4_key_search_if.sv
// rtl/arc4_key_search_if.sv - handshake, decrypter and plaintext-port bundle for arc4_key_search
interface arc4_key_search_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic        key_valid;
  logic        arc4_en;
  logic        arc4_rdy;
  logic [23:0] arc4_key;
  logic        pt_own;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_rddata;

  // Environment side: requests searches, models the decrypter and plaintext memory.
  modport master (
    output en, arc4_rdy, pt_rddata,
    input  rdy, key, key_valid, arc4_en, arc4_key, pt_own, pt_addr
  );

  // Key-search side.
  modport slave (
    input  en, arc4_rdy, pt_rddata,
    output rdy, key, key_valid, arc4_en, arc4_key, pt_own, pt_addr
  );
endinterface

// File: rtl/arc4_key_search.sv
// rtl/arc4_key_search.sv - brute-force ARC4 key search that accepts the first key giving printable plaintext
module arc4_key_search #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_END   = 24'hFFFFFF
) (
  input  logic             clk,
  input  logic             rst,
  arc4_key_search_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RD_LEN,
    CHECK,
    NEXT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] arc4_key_q, arc4_key_d;
  logic [23:0] key_q, key_d;
  logic        key_valid_q, key_valid_d;
  logic [7:0]  len_q, len_d;
  // Nine bits so that a 255-byte message can address byte 255 and still
  // step to 256 as the "all bytes seen" marker without wrapping to 0.
  logic [8:0]  addr_q, addr_d;

  // In CHECK, addr_q is the address being issued this cycle and pt_rddata
  // carries the byte at addr_q-1. On the first CHECK cycle (addr_q==1) that
  // byte is the length, which is not yet in len_q, so use it directly.
  logic        first_chk;
  logic [7:0]  len_eff;
  logic        byte_ok;
  logic [8:0]  last_addr;

  assign first_chk = (addr_q == 9'd1);
  assign len_eff   = first_chk ? bus.pt_rddata : len_q;
  assign byte_ok   = (bus.pt_rddata >= 8'h20) && (bus.pt_rddata <= 8'h7E);
  assign last_addr = {1'b0, len_q} + 9'd1;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      arc4_key_q  <= KEY_START;
      key_q       <= 24'h000000;
      key_valid_q <= 1'b0;
      len_q       <= 8'h00;
      addr_q      <= 9'd0;
    end else begin
      state_q     <= state_d;
      arc4_key_q  <= arc4_key_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    arc4_key_d  = arc4_key_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    len_d       = len_q;
    addr_d      = addr_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.en) begin
          arc4_key_d  = KEY_START;
          key_valid_d = 1'b0;
          state_d     = START;
        end
      end
      START: begin
        if (bus.arc4_rdy) begin
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!bus.arc4_rdy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.arc4_rdy) begin
          state_d = RD_LEN;
        end
      end
      RD_LEN: begin
        // Address 0 is on the bus this cycle; its data arrives in CHECK.
        addr_d  = 9'd1;
        state_d = CHECK;
      end
      CHECK: begin
        if (first_chk) begin
          if (bus.pt_rddata == 8'h00) begin
            key_d       = arc4_key_q;
            key_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            len_d  = bus.pt_rddata;
            addr_d = addr_q + 9'd1;
          end
        end else if (!byte_ok) begin
          state_d = NEXT;
        end else if (addr_q == last_addr) begin
          key_d       = arc4_key_q;
          key_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          addr_d = addr_q + 9'd1;
        end
      end
      NEXT: begin
        if (arc4_key_q == KEY_END) begin
          key_d       = KEY_END;
          key_valid_d = 1'b0;
          state_d     = DONE;
        end else begin
          arc4_key_d = arc4_key_q + 24'd1;
          state_d    = START;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state; the start pulse is gated by
  // arc4_rdy so it lasts exactly the one cycle in which START is left.
  always_comb begin
    bus.rdy       = (state_q == IDLE) || (state_q == DONE);
    bus.key       = key_q;
    bus.key_valid = key_valid_q;
    bus.arc4_key  = arc4_key_q;
    bus.arc4_en   = (state_q == START) && bus.arc4_rdy;
    bus.pt_own    = (state_q == RD_LEN) || (state_q == CHECK);
    bus.pt_addr   = 8'h00;
    if ((state_q == CHECK) && (addr_q <= {1'b0, len_eff})) begin
      bus.pt_addr = addr_q[7:0];
    end
  end

endmodule
